mem_ctrl: RTL and testbench

Memory access controller sitting directly downstream of the control unit: it accepts the CU's level-held `read_en`/`write_en` requests, runs them against a synchronous single-port block RAM or a small memory-mapped I/O page, and returns a one-cycle `done` pulse. It is the single path by which instruction fetch and LDR/STR reach storage. It enforces a release cycle between transactions so a request still asserted during `done` is never issued twice.

---
 rtl/mem_ctrl.sv | 170 +++++++++++++++++
 tb/tb_mem_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: memory access controller between the control unit and a
// synchronous single-port block RAM plus a 256-word MMIO page.
// Each accepted request yields exactly one registered done pulse. The
// enables must be seen low once before the next request is accepted.
module mem_ctrl #(
    parameter int unsigned MEM_WORDS    = 4096,
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [15:0] MMIO_BASE    = 16'hFF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        read_en,
    input  logic        write_en,
    output logic [15:0] data_out,
    output logic        done,
    output logic        bram_en,
    output logic        bram_we,
    output logic [15:0] bram_addr,
    output logic [15:0] bram_wdata,
    input  logic [15:0] bram_rdata,
    output logic [15:0] gpio_out,
    output logic        addr_err
);

    localparam int unsigned DW    = 16;
    localparam int unsigned LAT_W = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_RAM,
        S_ACCESS,
        S_DONE,
        S_RELEASE
    } state_t;

    typedef enum logic [1:0] {
        K_RAM,
        K_MMIO,
        K_OOR
    } kind_t;

    state_t           state;
    logic [DW-1:0]    req_addr;
    logic [DW-1:0]    req_wdata;
    logic             req_wr;
    logic [LAT_W-1:0] lat_cnt;
    logic [DW-1:0]    cycle_cnt;

    kind_t            in_kind_c;
    kind_t            req_kind_c;
    logic [DW-1:0]    req_off_c;

    // Classify a word address as RAM, MMIO page or unmapped
    function automatic kind_t decode(input logic [DW-1:0] a);
        if (32'(a) < MEM_WORDS) begin
            return K_RAM;
        end else if ((32'(a) >= 32'(MMIO_BASE)) &&
                     (32'(a) <= (32'(MMIO_BASE) + 32'd255))) begin
            return K_MMIO;
        end
        return K_OOR;
    endfunction

    assign in_kind_c  = decode(addr);
    assign req_kind_c = decode(req_addr);
    assign req_off_c  = req_addr - MMIO_BASE;

    // Request FSM, BRAM port, MMIO registers and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            req_addr   <= '0;
            req_wdata  <= '0;
            req_wr     <= 1'b0;
            lat_cnt    <= '0;
            cycle_cnt  <= '0;
            data_out   <= '0;
            done       <= 1'b0;
            bram_en    <= 1'b0;
            bram_we    <= 1'b0;
            bram_addr  <= '0;
            bram_wdata <= '0;
            gpio_out   <= '0;
            addr_err   <= 1'b0;
        end else begin
            cycle_cnt <= cycle_cnt + DW'(1);
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (read_en || write_en) begin
                        req_addr  <= addr;
                        req_wdata <= data_in;
                        // a simultaneous read+write is resolved as a write
                        req_wr    <= write_en;
                        if (read_en && write_en) begin
                            addr_err <= 1'b1;
                        end
                        if (in_kind_c == K_RAM) begin
                            bram_addr <= addr;
                            bram_en   <= 1'b1;
                            if (write_en) begin
                                bram_wdata <= data_in;
                                bram_we    <= 1'b1;
                                state      <= S_ACCESS;
                            end else begin
                                lat_cnt <= '0;
                                state   <= S_RD_RAM;
                            end
                        end else begin
                            state <= S_ACCESS;
                        end
                    end
                end
                S_RD_RAM: begin
                    bram_en <= 1'b0;
                    if (lat_cnt == LAT_W'(READ_LATENCY)) begin
                        data_out <= bram_rdata;
                        done     <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                S_ACCESS: begin
                    bram_en <= 1'b0;
                    bram_we <= 1'b0;
                    done    <= 1'b1;
                    state   <= S_DONE;
                    case (req_kind_c)
                        K_MMIO: begin
                            if (req_wr) begin
                                if (req_off_c == DW'(0)) begin
                                    gpio_out <= req_wdata;
                                end
                            end else if (req_off_c == DW'(0)) begin
                                data_out <= gpio_out;
                            end else if (req_off_c == DW'(1)) begin
                                data_out <= cycle_cnt;
                            end else begin
                                data_out <= '0;
                            end
                        end
                        K_OOR: begin
                            addr_err <= 1'b1;
                            if (!req_wr) begin
                                data_out <= '0;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
                S_DONE: begin
                    state <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (!read_en && !write_en) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: scoreboard bench for mem_ctrl with a behavioural BRAM.
// A second instance with READ_LATENCY=3 covers reset during a read.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr, data_in;
    logic        read_en, write_en;
    logic [15:0] data_out;
    logic        done, bram_en, bram_we;
    logic [15:0] bram_addr, bram_wdata, bram_rdata, gpio_out;
    logic        addr_err;

    logic        rst3;
    logic [15:0] addr3, data_in3;
    logic        rd3, wr3;
    logic [15:0] data_out3;
    logic        done3, bram_en3, bram_we3;
    logic [15:0] bram_addr3, bram_wdata3, gpio_out3;
    logic [15:0] p0, p1, p2;
    logic        addr_err3;

    logic [15:0] mem [0:4095];
    logic [15:0] rd_q;
    logic [15:0] ctr;
    logic [15:0] gpio_model;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          we_cnt = 0;

    typedef struct {
        string       tag;
        int          t0;
        int          lat;
        logic [15:0] data;
        logic [15:0] gpio;
    } sb_t;
    sb_t sb_q[$];

    always #5 clk = ~clk;

    mem_ctrl #(.MEM_WORDS(4096), .READ_LATENCY(1), .MMIO_BASE(16'hFF00)) u_dut (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in),
        .read_en(read_en), .write_en(write_en), .data_out(data_out), .done(done),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
        .gpio_out(gpio_out), .addr_err(addr_err)
    );

    mem_ctrl #(.MEM_WORDS(4096), .READ_LATENCY(3), .MMIO_BASE(16'hFF00)) u_dut3 (
        .clk(clk), .rst(rst3), .addr(addr3), .data_in(data_in3),
        .read_en(rd3), .write_en(wr3), .data_out(data_out3), .done(done3),
        .bram_en(bram_en3), .bram_we(bram_we3), .bram_addr(bram_addr3),
        .bram_wdata(bram_wdata3), .bram_rdata(p2),
        .gpio_out(gpio_out3), .addr_err(addr_err3)
    );

    // Single-port BRAM, one cycle read latency
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr[11:0]] <= bram_wdata;
            else         rd_q <= mem[bram_addr[11:0]];
        end
    end
    assign bram_rdata = rd_q;

    // Three-stage read pipeline returning addr ^ 0xA5A5
    always @(posedge clk) begin
        if (bram_en3) p0 <= bram_addr3 ^ 16'hA5A5;
        p1 <= p0;
        p2 <= p1;
    end

    // Reference free-running cycle counter and bench cycle index
    always @(posedge clk) begin
        if (rst) ctr <= 16'h0000;
        else     ctr <= ctr + 16'h0001;
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: pop scoreboard on every done pulse
    initial begin
        sb_t e;
        forever begin
            @(posedge clk);
            #1;
            if (bram_we) we_cnt++;
            if (done) begin
                done_cnt++;
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check({e.tag, "_lat"}, 32'(cyc - e.t0), 32'(e.lat));
                    check({e.tag, "_data"}, 32'(data_out), 32'(e.data));
                    check({e.tag, "_gpio"}, 32'(gpio_out), 32'(e.gpio));
                end
            end
        end
    end

    // Drive one request, push its expectation, wait for done, release
    task automatic req(input string tag, input logic rd, input logic wr,
                       input logic [15:0] a, input logic [15:0] d, input int lat,
                       input logic [15:0] exp, input bit is_ctr, input int exp_we,
                       input bit hold);
        int  we0, dn0, n;
        sb_t e;
        @(negedge clk);
        we0 = we_cnt;
        dn0 = done_cnt;
        read_en = rd; write_en = wr; addr = a; data_in = d;
        e.tag = tag; e.t0 = cyc + 1; e.lat = lat;
        e.data = is_ctr ? ctr + 16'h0001 : exp;
        e.gpio = gpio_model;
        sb_q.push_back(e);
        @(negedge clk);
        addr = ~a; data_in = ~d;
        n = 0;
        while (done_cnt == dn0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == dn0) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            sb_q.delete();
        end
        if (hold) repeat (6) @(negedge clk);
        read_en = 1'b0; write_en = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, "_done_cnt"}, 32'(done_cnt - dn0), 32'd1);
        check({tag, "_we_cnt"}, 32'(we_cnt - we0), 32'(exp_we));
    endtask

    initial begin
        int n;
        int d3;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        mem[0] = 16'h1234;
        rst = 1'b1; rst3 = 1'b1;
        addr = '0; data_in = '0; read_en = 1'b0; write_en = 1'b0;
        addr3 = '0; data_in3 = '0; rd3 = 1'b0; wr3 = 1'b0;
        gpio_model = 16'h0000;
        repeat (3) @(negedge clk);
        check("rst_done", 32'(done), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_bram_en", 32'(bram_en), 32'd0);
        check("rst_bram_we", 32'(bram_we), 32'd0);
        check("rst_bram_addr", 32'(bram_addr), 32'd0);
        check("rst_bram_wdata", 32'(bram_wdata), 32'd0);
        check("rst_gpio", 32'(gpio_out), 32'd0);
        check("rst_addr_err", 32'(addr_err), 32'd0);
        rst = 1'b0; rst3 = 1'b0;

        // RAM read held through done, write/read of the last RAM word
        req("rd0", 1'b1, 1'b0, 16'h0000, 16'h0000, 2, 16'h1234, 1'b0, 0, 1'b1);
        req("wr_last", 1'b0, 1'b1, 16'h0FFF, 16'hBEEF, 1, 16'h1234, 1'b0, 1, 1'b0);
        check("mem_last", 32'(mem[4095]), 32'h0000BEEF);
        req("rd_last", 1'b1, 1'b0, 16'h0FFF, 16'h0000, 2, 16'hBEEF, 1'b0, 0, 1'b0);
        check("err_after_ram", 32'(addr_err), 32'd0);

        // MMIO: gpio, cycle counter, unused word
        gpio_model = 16'h00A5;
        req("gpio_wr", 1'b0, 1'b1, 16'hFF00, 16'h00A5, 1, 16'hBEEF, 1'b0, 0, 1'b0);
        req("gpio_rd", 1'b1, 1'b0, 16'hFF00, 16'h0000, 1, 16'h00A5, 1'b0, 0, 1'b0);
        req("ctr_rd1", 1'b1, 1'b0, 16'hFF01, 16'h0000, 1, 16'h0000, 1'b1, 0, 1'b0);
        repeat (7) @(negedge clk);
        req("ctr_rd2", 1'b1, 1'b0, 16'hFF01, 16'h0000, 1, 16'h0000, 1'b1, 0, 1'b0);
        req("ctr_wr", 1'b0, 1'b1, 16'hFF01, 16'h0000, 1, data_out, 1'b0, 0, 1'b0);
        req("ctr_rd3", 1'b1, 1'b0, 16'hFF01, 16'h0000, 1, 16'h0000, 1'b1, 0, 1'b0);
        req("mmio_other_rd", 1'b1, 1'b0, 16'hFF05, 16'h0000, 1, 16'h0000, 1'b0, 0, 1'b0);
        req("mmio_other_wr", 1'b0, 1'b1, 16'hFF05, 16'h1111, 1, 16'h0000, 1'b0, 0, 1'b0);
        check("gpio_kept", 32'(gpio_out), 32'h00A5);
        check("err_after_mmio", 32'(addr_err), 32'd0);

        // Both enables high: write wins and flags an error
        req("both", 1'b1, 1'b1, 16'h0010, 16'h7777, 1, 16'h0000, 1'b0, 1, 1'b0);
        check("both_err", 32'(addr_err), 32'd1);
        req("both_rb", 1'b1, 1'b0, 16'h0010, 16'h0000, 2, 16'h7777, 1'b0, 0, 1'b0);

        // Reset clears the sticky flag and gpio
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        gpio_model = 16'h0000;
        check("rst2_err", 32'(addr_err), 32'd0);
        check("rst2_gpio", 32'(gpio_out), 32'd0);
        check("rst2_data", 32'(data_out), 32'd0);

        // Out of range accesses
        req("oor_rd", 1'b1, 1'b0, 16'h1000, 16'h0000, 1, 16'h0000, 1'b0, 0, 1'b0);
        check("oor_rd_err", 32'(addr_err), 32'd1);
        req("oor_wr", 1'b0, 1'b1, 16'h8000, 16'h5555, 1, 16'h0000, 1'b0, 0, 1'b0);
        check("oor_wr_err", 32'(addr_err), 32'd1);
        check("oor_mem0", 32'(mem[0]), 32'h00001234);
        req("rd0_again", 1'b1, 1'b0, 16'h0000, 16'h0000, 2, 16'h1234, 1'b0, 0, 1'b0);
        check("err_sticky", 32'(addr_err), 32'd1);

        // READ_LATENCY=3 instance: reset one cycle after acceptance
        @(negedge clk); addr3 = 16'h0005; rd3 = 1'b1;
        @(negedge clk); rst3 = 1'b1;
        @(negedge clk); rst3 = 1'b0; rd3 = 1'b0;
        d3 = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done3) d3++;
        end
        check("mid_rst_no_done", 32'(d3), 32'd0);
        check("mid_rst_data", 32'(data_out3), 32'd0);
        check("mid_rst_en", 32'(bram_en3), 32'd0);
        check("mid_rst_we", 32'(bram_we3), 32'd0);
        check("mid_rst_addr", 32'(bram_addr3), 32'd0);
        check("mid_rst_misc", 32'({bram_wdata3, gpio_out3} | 32'(addr_err3)), 32'd0);
        addr3 = 16'h0007; rd3 = 1'b1;
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (done3) break;
        end
        check("lat3_latency", 32'(n - 1), 32'd4);
        check("lat3_data", 32'(data_out3), 32'(16'h0007 ^ 16'hA5A5));
        @(negedge clk); rd3 = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
